// File: rtl/rgb_to_gray_pipe.sv
// Purpose : RGB to grey conversion (BT.601 luma, average, programmable weights or max).
// Latency : 3 cycles from iRed/iGreen/iBlue/iDVAL/iFVAL to oDATA/oDVAL/oFVAL in every mode.
// Backpr. : none; a new pixel is accepted every cycle.
// Ports   : iCLK/iRST clock and async active-high reset; iDVAL/iFVAL pixel and frame valid;
//           iRed/iGreen/iBlue unsigned channels; iMODE requested mode (latched at frame start);
//           iCOEF_WE/iCOEF_SEL/iCOEF write pending R/G/B weights; oDATA/oDVAL/oFVAL grey
//           result and aligned qualifiers; oPIX_CNT pixels accepted in the current frame.
module rgb_to_gray_pipe #(
  parameter int DATA_W = 10,
  parameter int COEF_W = 8,
  parameter int CNT_W  = 22
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic              iFVAL,
  input  logic [DATA_W-1:0] iRed,
  input  logic [DATA_W-1:0] iGreen,
  input  logic [DATA_W-1:0] iBlue,
  input  logic [1:0]        iMODE,
  input  logic              iCOEF_WE,
  input  logic [1:0]        iCOEF_SEL,
  input  logic [COEF_W-1:0] iCOEF,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic              oFVAL,
  output logic [CNT_W-1:0]  oPIX_CNT
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = DATA_W + COEF_W + 2;

  // Weights are written for 8 fractional bits and scaled up for wider COEF_W.
  localparam logic [COEF_W-1:0] LUMA_R = COEF_W'(77  << (COEF_W - 8));
  localparam logic [COEF_W-1:0] LUMA_G = COEF_W'(150 << (COEF_W - 8));
  localparam logic [COEF_W-1:0] LUMA_B = COEF_W'(29  << (COEF_W - 8));
  localparam logic [COEF_W-1:0] AVG_R  = COEF_W'(85  << (COEF_W - 8));
  localparam logic [COEF_W-1:0] AVG_G  = COEF_W'(86  << (COEF_W - 8));
  localparam logic [COEF_W-1:0] AVG_B  = COEF_W'(85  << (COEF_W - 8));

  localparam logic [SUM_W-1:0] HALF     = SUM_W'(1) << (COEF_W - 1);
  localparam logic [SUM_W-1:0] DATA_MAX = SUM_W'({DATA_W{1'b1}});
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_LUMA = 2'd0,
    MODE_AVG  = 2'd1,
    MODE_PROG = 2'd2,
    MODE_MAX  = 2'd3
  } mode_t;

  // Frame control and coefficient state
  logic              fval_prev;
  logic              frame_start;
  mode_t             act_mode;
  mode_t             cur_mode;
  logic [COEF_W-1:0] act_r, act_g, act_b;
  logic [COEF_W-1:0] pend_r, pend_g, pend_b;
  logic [COEF_W-1:0] c_r, c_g, c_b;

  // Pipeline
  logic              s1_vld, s1_fval, s1_max;
  logic [PROD_W-1:0] s1_a, s1_b, s1_c;
  logic [PROD_W-1:0] s1_mx_ab, s1_mx;
  logic              s2_vld, s2_fval, s2_max;
  logic [SUM_W-1:0]  s2_sum;
  logic [SUM_W-1:0]  s2_rnd;
  logic [CNT_W-1:0]  pix_cnt;

  assign frame_start = iFVAL & ~fval_prev;

  // The frame-start pixel already uses the mode/weights being latched this cycle.
  always_comb begin
    cur_mode = frame_start ? mode_t'(iMODE) : act_mode;
    c_r = LUMA_R;
    c_g = LUMA_G;
    c_b = LUMA_B;
    case (cur_mode)
      MODE_AVG: begin
        c_r = AVG_R;
        c_g = AVG_G;
        c_b = AVG_B;
      end
      MODE_PROG: begin
        c_r = frame_start ? pend_r : act_r;
        c_g = frame_start ? pend_g : act_g;
        c_b = frame_start ? pend_b : act_b;
      end
      default: ;
    endcase
  end

  // Active settings only move at a frame start; a coincident write lands in
  // pending only, so active picks up the previous pending value.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      fval_prev <= 1'b0;
      act_mode  <= MODE_LUMA;
      act_r     <= LUMA_R;
      act_g     <= LUMA_G;
      act_b     <= LUMA_B;
      pend_r    <= LUMA_R;
      pend_g    <= LUMA_G;
      pend_b    <= LUMA_B;
    end else begin
      fval_prev <= iFVAL;
      if (frame_start) begin
        act_mode <= mode_t'(iMODE);
        act_r    <= pend_r;
        act_g    <= pend_g;
        act_b    <= pend_b;
      end
      if (iCOEF_WE) begin
        case (iCOEF_SEL)
          2'd0:    pend_r <= iCOEF;
          2'd1:    pend_g <= iCOEF;
          2'd2:    pend_b <= iCOEF;
          default: ;
        endcase
      end
    end
  end

  // Max mode reuses the product registers to carry the raw channels.
  always_comb begin
    s1_mx_ab = (s1_a > s1_b) ? s1_a : s1_b;
    s1_mx    = (s1_mx_ab > s1_c) ? s1_mx_ab : s1_c;
    s2_rnd   = (s2_sum + HALF) >> COEF_W;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_vld  <= 1'b0;
      s1_fval <= 1'b0;
      s1_max  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_c    <= '0;
      s2_vld  <= 1'b0;
      s2_fval <= 1'b0;
      s2_max  <= 1'b0;
      s2_sum  <= '0;
      oDATA   <= '0;
      oDVAL   <= 1'b0;
      oFVAL   <= 1'b0;
    end else begin
      // S1: products or max candidates
      s1_vld  <= iDVAL;
      s1_fval <= iFVAL;
      s1_max  <= (cur_mode == MODE_MAX);
      if (cur_mode == MODE_MAX) begin
        s1_a <= PROD_W'(iRed);
        s1_b <= PROD_W'(iGreen);
        s1_c <= PROD_W'(iBlue);
      end else begin
        s1_a <= PROD_W'(iRed)   * PROD_W'(c_r);
        s1_b <= PROD_W'(iGreen) * PROD_W'(c_g);
        s1_c <= PROD_W'(iBlue)  * PROD_W'(c_b);
      end
      // S2: full-width sum or max
      s2_vld  <= s1_vld;
      s2_fval <= s1_fval;
      s2_max  <= s1_max;
      s2_sum  <= s1_max ? SUM_W'(s1_mx)
                        : SUM_W'(s1_a) + SUM_W'(s1_b) + SUM_W'(s1_c);
      // S3: round/saturate; oDATA holds between valid pixels
      oDVAL <= s2_vld;
      oFVAL <= s2_fval;
      if (s2_vld) begin
        if (s2_max)
          oDATA <= s2_sum[DATA_W-1:0];
        else if (s2_rnd > DATA_MAX)
          oDATA <= {DATA_W{1'b1}};
        else
          oDATA <= s2_rnd[DATA_W-1:0];
      end
    end
  end

  // Pixels outside a frame are converted but not counted.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pix_cnt <= '0;
    end else if (frame_start) begin
      pix_cnt <= iDVAL ? CNT_W'(1) : '0;
    end else if (iDVAL && iFVAL && (pix_cnt != CNT_MAX)) begin
      pix_cnt <= pix_cnt + CNT_W'(1);
    end
  end

  assign oPIX_CNT = pix_cnt;

endmodule

// File: doc/rgb_to_gray_pipe.md
RGB_TO_GRAY_PIPE -- requirements
Module: rgb_to_gray_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 10: width of each colour channel and of oDATA.
REQ-002 SHALL have parameter COEF_W, default 8: coefficient width; weights are fixed-point with COEF_W fractional bits.
REQ-003 SHALL have parameter CNT_W, default 22: width of the pixel counter.
REQ-004 SHALL have port iCLK, input, 1 bit: sole clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port iRST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port iDVAL, input, 1 bit: pixel valid qualifier for iRed, iGreen and iBlue.
REQ-007 SHALL have port iFVAL, input, 1 bit: frame valid; a rising edge marks the start of a frame.
REQ-008 SHALL have ports iRed, iGreen and iBlue, input, DATA_W bits each: unsigned colour channels.
REQ-009 SHALL have port iMODE, input, 2 bits: requested conversion mode.
REQ-010 SHALL have ports iCOEF_WE (1 bit), iCOEF_SEL (2 bits) and iCOEF (COEF_W bits), all inputs: programmable coefficient write.
REQ-011 SHALL have port oDATA, output, DATA_W bits: grey result.
REQ-012 SHALL have port oDVAL, output, 1 bit: oDATA valid.
REQ-013 SHALL have port oFVAL, output, 1 bit: iFVAL delayed to align with oDATA.
REQ-014 SHALL have port oPIX_CNT, output, CNT_W bits: count of pixels accepted in the current frame.

Function
REQ-015 SHALL use active mode 0 as luma BT.601, with coefficients R/G/B = 77/150/29 when COEF_W=8 (scaled by 2^(COEF_W-8) otherwise).
REQ-016 SHALL use active mode 1 as average, with coefficients 85/86/85 when COEF_W=8 (scaled likewise).
REQ-017 SHALL use active mode 2 as programmable, taking coefficients from the active coefficient registers.
REQ-018 SHALL use active mode 3 as max(R,G,B), with no multiply and no rounding.
REQ-019 SHALL compute modes 0-2 as sum = R*cR + G*cG + B*cB at full width, DATA_W+COEF_W+2 bits, with no overflow.
REQ-020 SHALL compute the modes 0-2 result as (sum + 2^(COEF_W-1)) >> COEF_W, saturated to 2^DATA_W-1.
REQ-021 SHALL be a 3-stage pipeline: S1 registers products or the max candidates, S2 the sum, S3 the round/saturate.
REQ-022 SHALL present oDATA, oDVAL and oFVAL exactly 3 cycles after the corresponding inputs, in every mode.
REQ-023 SHALL accept a new pixel every cycle, with no backpressure.
REQ-024 SHALL hold oDATA at its last value while oDVAL=0.
REQ-025 SHALL, on iCOEF_WE=1 with iCOEF_SEL 0/1/2, write iCOEF into pending cR/cG/cB respectively.
REQ-026 SHALL ignore a coefficient write with iCOEF_SEL=3.
REQ-027 SHALL detect a frame start (iFVAL=1 and registered previous iFVAL=0) and, on that cycle, copy pending coefficients to active and latch iMODE as the active mode.
REQ-028 SHALL change active mode and coefficients only at a frame start, and never mid-frame.
REQ-029 SHALL, when a coefficient write and a frame start occur in the same cycle, load the old pending value into active and let the new write update pending only.
REQ-030 SHALL compute a pixel with iDVAL=1 on the frame-start cycle using the newly latched mode and coefficients.
REQ-031 SHALL clear oPIX_CNT at a frame start, then count to 1 if iDVAL=1 on that same cycle.
REQ-032 SHALL otherwise increment oPIX_CNT on each iDVAL=1 cycle while iFVAL=1.
REQ-033 SHALL saturate oPIX_CNT at 2^CNT_W-1 with no wrap.
REQ-034 SHALL not count pixels with iDVAL=1 while iFVAL=0, but SHALL still convert them.

Reset
REQ-035 SHALL, while iRST=1, asynchronously force oDATA=0, oDVAL=0, oFVAL=0, oPIX_CNT=0 and all pipeline registers to 0.
REQ-036 SHALL, while iRST=1, force active and pending coefficients to the mode 0 defaults, active mode to 0, and the previous-iFVAL register to 0.
REQ-037 SHALL discard all pixels in flight at reset, with no oDVAL pulse after deassertion until 3 cycles after a new iDVAL.
REQ-038 SHALL treat iFVAL=1 on the first cycle after reset release as a frame start.

Verification
REQ-039 SHALL cover: mode 0, frame start, R=G=B=1023 then R=1023,G=0,B=0 -> oDATA 1023 then 308, each exactly 3 cycles after input, oDVAL aligned.
REQ-040 SHALL cover: iMODE=1 at frame start, R=300,G=600,B=900 -> oDATA=600; iMODE=3, R=10,G=700,B=3 -> 700.
REQ-041 SHALL cover: write cR=cG=cB=255 mid-frame with mode 2 requested -> output unchanged (mode 0) until the next iFVAL rise; then R=G=B=1023 -> oDATA=1023 (saturated).
REQ-042 SHALL cover: coefficient write coincident with a frame start -> active takes the old pending value, the new value applies from the following frame.
REQ-043 SHALL cover: 5 iDVAL pulses in a frame, 2 pulses with iFVAL=0 -> oPIX_CNT=5; the next frame start clears it to 0, or 1 if iDVAL=1 on that cycle.
REQ-044 SHALL cover: iRST asserted asynchronously with 3 pixels in flight -> outputs 0 immediately, no oDVAL after release, coefficients back to 77/150/29.
